sram_mem_controller: RTL and testbench

- Sequences the MEM-stage data access onto a 16-bit external SRAM and produces the pipeline freeze that holds the pipeline registers during the access.
- A 32-bit load or store from the EXE/MEM register is split into two 16-bit SRAM phases, low half first.
- `ready` gates advance of all pipeline registers, including MEM/WB; the captured word feeds MEM/WB `memory_data`.

---
 rtl/sram_mem_controller_pkg.sv | 36 +++
 rtl/register.sv | 20 ++
 rtl/sram_mem_controller_phase_counter.sv | 26 ++
 rtl/sram_mem_controller.sv | 151 +++++++++++++++
 tb/tb_sram_mem_controller.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_mem_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM access controller.
// The address helper maps a byte address onto the 16-bit SRAM halfword space.
package sram_mem_controller_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned WORD_W      = 32;

  localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR     = 32'd1024;
  localparam int unsigned       DEFAULT_ACCESS_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  // Request captured from EXE/MEM when an access starts
  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] wdata;
  } req_t;

  // {word[16:0], half} where word = (address - base) >> 2, wrapping subtraction
  function automatic logic [SRAM_ADDR_W-1:0] sram_halfword(
    input logic [WORD_W-1:0] address,
    input logic [WORD_W-1:0] base,
    input logic              half
  );
    return SRAM_ADDR_W'({(address - base) >> 2, half});
  endfunction

endpackage

// File: rtl/register.sv
// Generic enable-gated register with synchronous active-high clear.
module register #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sram_mem_controller_phase_counter.sv
// Cycle counter for one 16-bit SRAM phase; last marks the final cycle.
module sram_phase_counter
  import sram_mem_controller_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  // Clear wins over enable so the terminal cycle restarts the next phase at 0
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(ACCESS_CYCLES - 1));

endmodule

// File: rtl/sram_mem_controller.sv
// Splits a 32-bit MEM-stage load/store into two 16-bit SRAM phases (low half
// first) and drives ready, which freezes the pipeline while the access runs.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter int unsigned       ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [WORD_W-1:0]      address,
  input  logic [WORD_W-1:0]      write_data,
  output logic [WORD_W-1:0]      read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  state_t                 state;
  state_t                 next_state;
  req_t                   req_d;
  req_t                   req_q;
  logic                   req_load;
  logic                   cnt_clear;
  logic                   cnt_enable;
  logic                   cnt_last;
  logic [CNT_W-1:0]       cnt_value;
  logic                   lo_capture;
  logic                   hi_capture;
  logic [SRAM_DATA_W-1:0] rd_lo;
  logic [SRAM_DATA_W-1:0] rd_hi;

  // Both request lines high is treated as a store
  assign req_d = '{write: wr_en, address: address, wdata: write_data};

  register #(.WIDTH($bits(req_t))) u_req_reg (
    .clock  (clock),
    .reset  (reset),
    .enable (req_load),
    .d      (req_d),
    .q      (req_q)
  );

  register #(.WIDTH(SRAM_DATA_W)) u_rd_lo_reg (
    .clock  (clock),
    .reset  (reset),
    .enable (lo_capture),
    .d      (sram_dq_in),
    .q      (rd_lo)
  );

  register #(.WIDTH(SRAM_DATA_W)) u_rd_hi_reg (
    .clock  (clock),
    .reset  (reset),
    .enable (hi_capture),
    .d      (sram_dq_in),
    .q      (rd_hi)
  );

  assign read_data = {rd_hi, rd_lo};

  sram_phase_counter #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_phase_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .count  (cnt_value),
    .last   (cnt_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and SRAM strobes; we_n releases on the last phase cycle for hold
  always_comb begin
    next_state  = state;
    ready       = 1'b0;
    req_load    = 1'b0;
    cnt_clear   = 1'b0;
    cnt_enable  = 1'b0;
    lo_capture  = 1'b0;
    hi_capture  = 1'b0;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;

    case (state)
      IDLE: begin
        ready     = ~(rd_en | wr_en);
        cnt_clear = 1'b1;
        if (rd_en || wr_en) begin
          req_load   = 1'b1;
          next_state = LOW;
        end
      end

      LOW: begin
        cnt_enable = 1'b1;
        sram_addr  = sram_halfword(req_q.address, BASE_ADDR, 1'b0);
        if (req_q.write) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = req_q.wdata[15:0];
          sram_we_n   = cnt_last;
        end else begin
          lo_capture = cnt_last;
        end
        if (cnt_last) begin
          cnt_clear  = 1'b1;
          next_state = HIGH;
        end
      end

      HIGH: begin
        cnt_enable = 1'b1;
        sram_addr  = sram_halfword(req_q.address, BASE_ADDR, 1'b1);
        if (req_q.write) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = req_q.wdata[31:16];
          sram_we_n   = cnt_last;
        end else begin
          hi_capture = cnt_last;
        end
        if (cnt_last) begin
          cnt_clear  = 1'b1;
          next_state = DONE;
        end
      end

      DONE: begin
        ready      = 1'b1;
        next_state = IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench: directed and random loads/stores against a word-level
// memory model, plus a 3-cycle-phase instance for back-to-back timing.
module tb_sram_mem_controller;
  import sram_mem_controller_pkg::*;

  localparam int unsigned AC    = 2;
  localparam int unsigned AC3   = 3;
  localparam logic [31:0] BASE  = 32'd1024;
  localparam int unsigned NHW   = 262144;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        rd_en3, wr_en3;
  logic [31:0] address3, write_data3, read_data3;
  logic        ready3;
  logic [17:0] sram_addr3;
  logic [15:0] sram_dq_out3, sram_dq_in3;
  logic        sram_dq_oe3, sram_we_n3;

  logic [15:0] sram  [0:NHW-1];
  logic [15:0] sram3 [0:NHW-1];
  logic [15:0] ref_mem  [0:NHW-1];
  logic [15:0] ref_mem3 [0:NHW-1];
  logic [31:0] exp_rd;

  int checks = 0;
  int errors = 0;

  sram_mem_controller u_dut (
    .clock       (clock),
    .reset       (reset),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
  );

  sram_mem_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(AC3)) u_dut3 (
    .clock       (clock),
    .reset       (reset),
    .rd_en       (rd_en3),
    .wr_en       (wr_en3),
    .address     (address3),
    .write_data  (write_data3),
    .read_data   (read_data3),
    .ready       (ready3),
    .sram_addr   (sram_addr3),
    .sram_dq_out (sram_dq_out3),
    .sram_dq_in  (sram_dq_in3),
    .sram_dq_oe  (sram_dq_oe3),
    .sram_we_n   (sram_we_n3)
  );

  // Asynchronous SRAM: combinational read, write while we_n is low at the edge
  assign sram_dq_in  = sram[sram_addr];
  assign sram_dq_in3 = sram3[sram_addr3];

  always @(posedge clock) begin
    if (!sram_we_n) sram[sram_addr] <= sram_dq_out;
    if (!sram_we_n3) sram3[sram_addr3] <= sram_dq_out3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on the default instance; rst_at > 0 asserts reset in that cycle
  task automatic access(input bit do_wr, input bit do_rd, input logic [31:0] addr,
                        input logic [31:0] wd, input int rst_at);
    int unsigned lo_hw, hi_hw, k;
    bit          hi;
    lo_hw = (((addr - BASE) >> 2) % 32'd131072) * 2;
    hi_hw = lo_hw + 1;
    @(negedge clock);
    wr_en = do_wr; rd_en = do_rd; address = addr; write_data = wd;
    #1;
    chk("idle_ready", 32'(ready), 32'd0);
    for (int c = 1; c <= int'(2 * AC + 2); c++) begin
      @(negedge clock);
      if (c == 1) begin
        rd_en = 1'b0; wr_en = 1'b0; address = $urandom(); write_data = $urandom();
      end
      if (c == rst_at) reset = 1'b1;
      if (rst_at > 0 && c == rst_at + 1) begin
        reset = 1'b0;
        #1;
        exp_rd = '0;
        if (do_wr) begin
          ref_mem[lo_hw] = wd[15:0];
          if (rst_at >= int'(AC + 1)) ref_mem[hi_hw] = wd[31:16];
        end
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
        return;
      end
      #1;
      if (c <= int'(2 * AC)) begin
        hi = (c > int'(AC));
        k  = hi ? c - AC - 1 : c - 1;
        chk("busy_ready", 32'(ready), 32'd0);
        chk("phase_addr", 32'(sram_addr), hi ? hi_hw : lo_hw);
        chk("phase_oe", 32'(sram_dq_oe), 32'(do_wr));
        chk("phase_we_n", 32'(sram_we_n), (do_wr && k < AC - 1) ? 32'd0 : 32'd1);
        if (do_wr) begin
          chk("phase_dq_out", 32'(sram_dq_out), hi ? 32'(wd[31:16]) : 32'(wd[15:0]));
          chk("wr_keeps_rdata", read_data, exp_rd);
        end
      end else if (c == int'(2 * AC + 1)) begin
        if (do_wr) begin
          ref_mem[lo_hw] = wd[15:0];
          ref_mem[hi_hw] = wd[31:16];
        end else begin
          exp_rd = {ref_mem[hi_hw], ref_mem[lo_hw]};
        end
        chk("done_ready", 32'(ready), 32'd1);
        chk("done_we_n", 32'(sram_we_n), 32'd1);
        chk("done_oe", 32'(sram_dq_oe), 32'd0);
        chk("done_rdata", read_data, exp_rd);
      end else begin
        chk("after_ready", 32'(ready), 32'd1);
        chk("after_rdata", read_data, exp_rd);
        chk("mem_lo", 32'(sram[lo_hw]), 32'(ref_mem[lo_hw]));
        chk("mem_hi", 32'(sram[hi_hw]), 32'(ref_mem[hi_hw]));
      end
    end
  endtask

  initial begin
    logic [15:0] v;
    int          op;
    logic [31:0] a;
    for (int i = 0; i < int'(NHW); i++) begin
      v = (i < 2048) ? 16'($urandom()) : 16'h0;
      sram[i] = v; ref_mem[i] = v;
      v = (i < 2048) ? 16'($urandom()) : 16'h0;
      sram3[i] = v; ref_mem3[i] = v;
    end
    exp_rd = '0;
    reset = 1'b1;
    rd_en = 1'b1; wr_en = 1'b0; address = BASE; write_data = '0;
    rd_en3 = 1'b0; wr_en3 = 1'b0; address3 = BASE; write_data3 = '0;

    repeat (3) @(negedge clock);
    #1;
    chk("reset_we_n", 32'(sram_we_n), 32'd1);
    chk("reset_oe", 32'(sram_dq_oe), 32'd0);
    chk("reset_rdata", read_data, 32'd0);
    chk("reset_addr", 32'(sram_addr), 32'd0);
    chk("reset_ready_req", 32'(ready), 32'd0);
    chk("reset3_ready", 32'(ready3), 32'd1);
    @(negedge clock);
    reset = 1'b0; rd_en = 1'b0;
    #1;
    chk("idle_no_req", 32'(ready), 32'd1);

    // Directed store, load, simultaneous request, reload
    access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 0);
    chk("store_hw2", 32'(sram[2]), 32'h0000BEEF);
    chk("store_hw3", 32'(sram[3]), 32'h0000DEAD);
    access(1'b0, 1'b1, 32'd1028, 32'h0, 0);
    chk("load_word", read_data, 32'hDEADBEEF);
    access(1'b1, 1'b1, 32'd1024, 32'h12345678, 0);
    chk("both_hw0", 32'(sram[0]), 32'h00005678);
    chk("both_hw1", 32'(sram[1]), 32'h00001234);
    chk("both_rdata", read_data, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 0);
    chk("reload_word", read_data, 32'h12345678);

    // Reset in the first HIGH cycle of a store
    access(1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, int'(AC + 1));

    // Random mix, including wrapped/aliased addresses below BASE
    for (int n = 0; n < 24; n++) begin
      op = int'($urandom_range(0, 2));
      a  = ($urandom_range(0, 3) == 0) ? $urandom() : BASE + 32'($urandom_range(0, 2047));
      access(op != 0, op != 1, a, $urandom(), 0);
    end

    // Back-to-back loads on the 3-cycle instance
    @(negedge clock);
    rd_en3 = 1'b1; address3 = BASE;
    #1;
    chk("b2b_c0_ready", 32'(ready3), 32'd0);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      if (c == 8) address3 = BASE + 32'd8;
      if (c == 9) rd_en3 = 1'b0;
      #1;
      chk($sformatf("b2b_ready_c%0d", c), 32'(ready3),
          (c == 7 || c == 15 || c == 16) ? 32'd1 : 32'd0);
      chk("b2b_we_n", 32'(sram_we_n3), 32'd1);
      chk("b2b_oe", 32'(sram_dq_oe3), 32'd0);
      if (c >= 1 && c <= 3)   chk("b2b_addr_a0", 32'(sram_addr3), 32'd0);
      if (c >= 4 && c <= 6)   chk("b2b_addr_a1", 32'(sram_addr3), 32'd1);
      if (c >= 9 && c <= 11)  chk("b2b_addr_b0", 32'(sram_addr3), 32'd4);
      if (c >= 12 && c <= 14) chk("b2b_addr_b1", 32'(sram_addr3), 32'd5);
      if (c == 7) chk("b2b_rdata_a", read_data3, {ref_mem3[1], ref_mem3[0]});
      if (c >= 15) chk("b2b_rdata_b", read_data3, {ref_mem3[5], ref_mem3[4]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
